// File: rtl/mbf_merge_pkg.sv
// mbf_merge_pkg: shared types and constants for the MBF band merger.
//   merge_state_e : IDLE / RUN / DONE control states
//   SAMPLE_W      : width of one band sample
//   PAIR_W        : width of a {lpf, hpf} pair (also the checksum width)
//   SAT_MAX       : saturation ceiling of the recombined sample
package mbf_merge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } merge_state_e;

  localparam int SAMPLE_W = 8;
  localparam int PAIR_W   = 16;
  localparam logic [SAMPLE_W-1:0] SAT_MAX = 8'hFF;

  // Unsigned add with clamp at SAT_MAX when the carry bit is set.
  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SAMPLE_W] ? SAT_MAX : s[SAMPLE_W-1:0];
  endfunction

  // Rotate-left-by-one then XOR: running signature over delivered pairs.
  function automatic logic [PAIR_W-1:0] fold_sig(input logic [PAIR_W-1:0] sig,
                                                 input logic [PAIR_W-1:0] data);
    return {sig[PAIR_W-2:0], sig[PAIR_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/mbf_sync_fifo.sv
// mbf_sync_fifo: single-clock FIFO with extra-MSB pointers.
//   clk, reset (async, active-low)
//   wr_en/wr_data : write request; dropped when full (fullness judged before a same-cycle pop)
//   rd_en/rd_data : rd_data always shows the head; rd_en pops it when non-empty
//   full, empty   : occupancy flags
module mbf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  // Same index with opposite wrap bit means the writer lapped the reader.
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mbf_band_merge.sv
// mbf_band_merge: pairs LPF sample k with HPF sample k and emits the pair
// plus a saturated sum over valid/ready, raising done after N_SAMPLES pairs.
//   clk, reset (async, active-low)
//   y/y_valid, z/z_valid : unaligned input streams, no backpressure
//   out_ready            : downstream accept
//   out_valid, out_pair, out_sum : registered output stage
//   pair_cnt, done       : handshake count, sticky completion
//   ovf_y, ovf_z         : sticky drop flags per band
//   checksum             : only when MBF_MERGE_CHECKSUM_EN is defined
module mbf_band_merge
  import mbf_merge_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int N_SAMPLES = 527,
  parameter int CNT_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] y,
  input  logic                y_valid,
  input  logic [SAMPLE_W-1:0] z,
  input  logic                z_valid,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [PAIR_W-1:0]   out_pair,
  output logic [SAMPLE_W-1:0] out_sum,
  output logic [CNT_W-1:0]    pair_cnt,
  output logic                done,
  output logic                ovf_y,
  output logic                ovf_z
`ifdef MBF_MERGE_CHECKSUM_EN
  ,
  output logic [PAIR_W-1:0]   checksum
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(N_SAMPLES);

  merge_state_e        state_r;
  merge_state_e        state_nxt_s;
  logic [SAMPLE_W-1:0] y_head_s;
  logic [SAMPLE_W-1:0] z_head_s;
  logic                y_full_s;
  logic                y_empty_s;
  logic                z_full_s;
  logic                z_empty_s;
  logic                accept_s;
  logic                y_wr_s;
  logic                z_wr_s;
  logic                load_s;
  logic                hs_s;
  logic                count_s;
  logic                last_hs_s;
  logic                out_valid_r;
  logic [PAIR_W-1:0]   out_pair_r;
  logic [SAMPLE_W-1:0] out_sum_r;
  logic [CNT_W-1:0]    pair_cnt_r;
  logic                done_r;
  logic                ovf_y_r;
  logic                ovf_z_r;

  assign accept_s  = (state_r != DONE);
  assign y_wr_s    = y_valid & accept_s;
  assign z_wr_s    = z_valid & accept_s;
  assign hs_s      = out_valid_r & out_ready;
  // Handshakes of a pair loaded alongside the final one are not counted.
  assign count_s   = hs_s & (pair_cnt_r != FINAL_CNT);
  assign last_hs_s = count_s & (pair_cnt_r == LAST_CNT);
  assign load_s    = ~y_empty_s & ~z_empty_s & (~out_valid_r | out_ready) & accept_s;

  mbf_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo_y (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (y_wr_s),
    .wr_data (y),
    .rd_en   (load_s),
    .rd_data (y_head_s),
    .full    (y_full_s),
    .empty   (y_empty_s)
  );

  mbf_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo_z (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (z_wr_s),
    .wr_data (z),
    .rd_en   (load_s),
    .rd_data (z_head_s),
    .full    (z_full_s),
    .empty   (z_empty_s)
  );

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state: start on first input activity, finish on the last counted handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (y_valid | z_valid) state_nxt_s = RUN;
        else                   state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_hs_s) state_nxt_s = DONE;
        else           state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output stage: a load overrides the clearing effect of a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_pair_r  <= '0;
      out_sum_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_pair_r  <= {y_head_s, z_head_s};
      out_sum_r   <= sat_add(y_head_s, z_head_s);
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Pair counter and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_cnt_r <= '0;
      done_r     <= 1'b0;
      ovf_y_r    <= 1'b0;
      ovf_z_r    <= 1'b0;
    end else begin
      if (count_s)             pair_cnt_r <= pair_cnt_r + CNT_W'(1);
      if (last_hs_s)           done_r     <= 1'b1;
      if (y_wr_s && y_full_s)  ovf_y_r    <= 1'b1;
      if (z_wr_s && z_full_s)  ovf_z_r    <= 1'b1;
    end
  end

`ifdef MBF_MERGE_CHECKSUM_EN
  logic [PAIR_W-1:0] checksum_r;

  // Signature over every pair that leaves on a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    checksum_r <= '0;
    else if (hs_s) checksum_r <= fold_sig(checksum_r, out_pair_r);
  end

  assign checksum = checksum_r;
`endif

  assign out_valid = out_valid_r;
  assign out_pair  = out_pair_r;
  assign out_sum   = out_sum_r;
  assign pair_cnt  = pair_cnt_r;
  assign done      = done_r;
  assign ovf_y     = ovf_y_r;
  assign ovf_z     = ovf_z_r;

endmodule

// File: tb/tb_mbf_band_merge.sv
// tb_mbf_band_merge: directed bench for mbf_band_merge with a queue-level
// reference model compared on every falling edge, plus literal expectations.
// Covers the checksum output when MBF_MERGE_CHECKSUM_EN is defined.
module tb_mbf_band_merge;

  localparam int DEP = 8;
  localparam int N   = 527;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  y, z;
  logic        y_valid, z_valid, out_ready;
  logic        out_valid;
  logic [15:0] out_pair;
  logic [7:0]  out_sum;
  logic [9:0]  pair_cnt;
  logic        done, ovf_y, ovf_z;
`ifdef MBF_MERGE_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_pass  = 0;
  int n_total = 0;

  mbf_band_merge #(.DEPTH(DEP), .N_SAMPLES(N), .CNT_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .y         (y),
    .y_valid   (y_valid),
    .z         (z),
    .z_valid   (z_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pair  (out_pair),
    .out_sum   (out_sum),
    .pair_cnt  (pair_cnt),
    .done      (done),
    .ovf_y     (ovf_y),
    .ovf_z     (ovf_z)
`ifdef MBF_MERGE_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (queues) ----------------
  logic [7:0]  qy[$];
  logic [7:0]  qz[$];
  logic        m_valid, m_done, m_ovf_y, m_ovf_z;
  logic [15:0] m_pair, m_ck;
  logic [7:0]  m_sum;
  int          m_cnt;
  logic        m_hs, m_ld, m_fy, m_fz, m_done_old;
  logic [7:0]  m_a, m_b;
  int          m_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qy.delete(); qz.delete();
      m_valid = 1'b0; m_done = 1'b0; m_ovf_y = 1'b0; m_ovf_z = 1'b0;
      m_pair = 16'h0000; m_sum = 8'h00; m_cnt = 0; m_ck = 16'h0000;
    end else begin
      m_done_old = m_done;
      m_hs = m_valid && out_ready;
      m_ld = !m_done && qy.size() > 0 && qz.size() > 0 && (!m_valid || out_ready);
      m_fy = (qy.size() == DEP);
      m_fz = (qz.size() == DEP);
      if (m_hs) begin
        m_ck = {m_ck[14:0], m_ck[15]} ^ m_pair;
        if (m_cnt < N) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == N) m_done = 1'b1;
        end
      end
      if (m_ld) begin
        m_a = qy.pop_front();
        m_b = qz.pop_front();
        m_s = int'(m_a) + int'(m_b);
        if (m_s > 255) m_s = 255;
        m_pair  = {m_a, m_b};
        m_sum   = m_s[7:0];
        m_valid = 1'b1;
      end else if (m_hs) begin
        m_valid = 1'b0;
      end
      if (!m_done_old) begin
        if (y_valid) begin
          if (m_fy) m_ovf_y = 1'b1; else qy.push_back(y);
        end
        if (z_valid) begin
          if (m_fz) m_ovf_z = 1'b1; else qz.push_back(z);
        end
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("m_out_pair", {16'b0, out_pair}, {16'b0, m_pair});
        chk("m_out_sum", {24'b0, out_sum}, {24'b0, m_sum});
      end
      chk("m_pair_cnt", {22'b0, pair_cnt}, m_cnt);
      chk("m_done", {31'b0, done}, {31'b0, m_done});
      chk("m_ovf_y", {31'b0, ovf_y}, {31'b0, m_ovf_y});
      chk("m_ovf_z", {31'b0, ovf_z}, {31'b0, m_ovf_z});
`ifdef MBF_MERGE_CHECKSUM_EN
      chk("m_checksum", {16'b0, checksum}, {16'b0, m_ck});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic yv, input logic [7:0] yd, input logic zv,
                       input logic [7:0] zd, input logic rdy);
    y_valid = yv; y = yd; z_valid = zv; z = zd; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(); step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pair", {16'b0, out_pair}, 32'd0);
    chk("rst_cnt", {22'b0, pair_cnt}, 32'd0);
    chk("rst_flags", {29'b0, done, ovf_y, ovf_z}, 32'd0);
    reset = 1'b1;
    step();

    // Basic pair with one-cycle latency.
    drive(1'b1, 8'h40, 1'b1, 8'h30, 1'b1); step();
    chk("t1_valid_early", {31'b0, out_valid}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_pair", {16'b0, out_pair}, 32'h4030);
    chk("t1_sum", {24'b0, out_sum}, 32'h70);
    step();
    chk("t1_cnt", {22'b0, pair_cnt}, 32'd1);

    // Saturation.
    drive(1'b1, 8'hC0, 1'b1, 8'h80, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t2_pair", {16'b0, out_pair}, 32'hC080);
    chk("t2_sum", {24'b0, out_sum}, 32'hFF);
    step();

    // Skew: LPF runs ahead by five samples.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h01 + i), 1'b0, 8'h00, 1'b1); step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'h11 + i), 1'b1); step();
      if (i > 0) chk("t3_pair", {16'b0, out_pair}, {16'b0, 8'(8'h01 + i - 1), 8'(8'h11 + i - 1)});
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t3_pair_last", {16'b0, out_pair}, 32'h0515);
    step();
    chk("t3_cnt", {22'b0, pair_cnt}, 32'd7);
    chk("t3_ovf", {30'b0, ovf_y, ovf_z}, 32'd0);

    // Overflow on the LPF side.
    for (int i = 0; i < DEP + 1; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b1); step();
      if (i == DEP - 1) chk("t4_no_ovf_yet", {31'b0, ovf_y}, 32'd0);
    end
    chk("t4_ovf_y", {31'b0, ovf_y}, 32'd1);
    chk("t4_ovf_z", {31'b0, ovf_z}, 32'd0);
    for (int i = 0; i < DEP; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'h20 + i), 1'b1); step();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t4_pair_last", {16'b0, out_pair}, 32'hA727);
    step();
    chk("t4_cnt", {22'b0, pair_cnt}, 32'd15);

    // Backpressure.
    drive(1'b1, 8'h55, 1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h66, 1'b1, 8'h33, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_hold_pair", {16'b0, out_pair}, 32'h5522);
      chk("t5_hold_sum", {24'b0, out_sum}, 32'h77);
      chk("t5_hold_cnt", {22'b0, pair_cnt}, 32'd15);
    end
    out_ready = 1'b1; step();
    chk("t5_rel_cnt", {22'b0, pair_cnt}, 32'd16);
    chk("t5_rel_valid", {31'b0, out_valid}, 32'd1);
    chk("t5_rel_pair", {16'b0, out_pair}, 32'h6633);
    chk("t5_rel_sum", {24'b0, out_sum}, 32'h99);
    step();
    chk("t5_cnt", {22'b0, pair_cnt}, 32'd17);

    // Completion: remaining 510 pairs, back to back.
    for (int j = 0; j < N - 17; j++) begin
      drive(1'b1, 8'(j), 1'b1, 8'(j * 7), 1'b1); step();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t6_cnt_526", {22'b0, pair_cnt}, 32'd526);
    chk("t6_not_done", {31'b0, done}, 32'd0);
    step();
    chk("t6_cnt_527", {22'b0, pair_cnt}, 32'd527);
    chk("t6_done", {31'b0, done}, 32'd1);
    for (int i = 0; i < DEP + 2; i++) begin
      drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1); step();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); step();
    chk("t6_ign_cnt", {22'b0, pair_cnt}, 32'd527);
    chk("t6_ign_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_ign_ovf_z", {31'b0, ovf_z}, 32'd0);
    chk("t6_still_done", {31'b0, done}, 32'd1);

    // Reset mid-stream.
    reset = 1'b0; step(); reset = 1'b1; step();
    for (int i = 0; i < DEP + 1; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'h30 + i), 1'b1); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0, 8'h00, 1'b1); step();
    end
    chk("t7_pre_cnt", {22'b0, pair_cnt}, 32'd1);
    chk("t7_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("t7_pre_ovf_z", {31'b0, ovf_z}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t7_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t7_rst_pair", {16'b0, out_pair}, 32'd0);
    chk("t7_rst_sum", {24'b0, out_sum}, 32'd0);
    chk("t7_rst_cnt", {22'b0, pair_cnt}, 32'd0);
    chk("t7_rst_flags", {29'b0, done, ovf_y, ovf_z}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    reset = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
